// File: rtl/gf180mcu_osu_sc_12t_tiebank_seq.sv
// rtl/gf180mcu_osu_sc_12t_tiebank_seq.sv - sequenced tie-off bank releasing groups of straps from SAFE_VAL to TIE_VAL
// Optional feature macro: GF180MCU_OSU_TIEBANK_OVERRIDE_EN (adds OVR / OVR_VAL override ports)
module gf180mcu_osu_sc_12t_tiebank_seq #(
  parameter int               WIDTH    = 8,
  parameter int               GROUPS   = 4,
  parameter int               STEP_CYC = 4,
  parameter logic [WIDTH-1:0] TIE_VAL  = '0,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             HOLD,
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
  input  logic             OVR,
  input  logic [WIDTH-1:0] OVR_VAL,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             DONE
);

  // Bits per release group and counter widths; counters saturate, never wrap.
  localparam int GW  = WIDTH / GROUPS;
  localparam int SW  = $clog2(STEP_CYC + 1);
  localparam int GCW = $clog2(GROUPS + 1);

  localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_CYC - 1);
  localparam logic [GCW-1:0] GRP_LAST  = GCW'(GROUPS - 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      sync_q;
  logic            rst_sync;
  logic [SW-1:0]   step_cnt;
  logic [SW-1:0]   step_nxt;
  logic [GCW-1:0]  grp_cnt;
  logic [GCW-1:0]  grp_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] y_base;
  logic [WIDTH-1:0] y_implied;
  logic            done_nxt;
  logic            ovr_act;
  logic            ovr_fall;
  logic            hold_act;
  logic            step_hit;
  logic            last_grp;

`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
  logic ovr_q;

  // Remember last sampled OVR so its falling edge can restore the group-correct pattern.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= OVR;
    end
  end

  assign ovr_act  = OVR;
  assign ovr_fall = !OVR && ovr_q;
`else
  assign ovr_act  = 1'b0;
  assign ovr_fall = 1'b0;
`endif

  // Two-flop synchroniser for RN deassertion; assertion stays asynchronous.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync = sync_q[1];

  // HOLD is ignored while waiting on the synchroniser; SYNC has priority.
  assign hold_act = HOLD && (state != ST_SYNC);
  assign step_hit = (state == ST_STEP) && (step_cnt == STEP_LAST);
  assign last_grp = (grp_cnt == GRP_LAST);

  // State register.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an active override freezes the FSM.
  always_comb begin
    state_nxt = state;
    if (!ovr_act) begin
      case (state)
        ST_SYNC: begin
          if (rst_sync) begin
            state_nxt = ST_STEP;
          end
        end
        ST_STEP: begin
          if (hold_act) begin
            state_nxt = ST_STEP;
          end else if (step_hit && last_grp) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (hold_act) begin
            state_nxt = ST_STEP;
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  // Pattern implied by the release count: released groups at TIE_VAL, the rest at SAFE_VAL.
  always_comb begin
    y_implied = SAFE_VAL;
    for (int g = 0; g < GROUPS; g++) begin
      if (g < int'(grp_cnt)) begin
        y_implied[g*GW +: GW] = TIE_VAL[g*GW +: GW];
      end
    end
  end

  // Output/counter next values; Y and DONE are registered below so no input reaches them combinationally.
  always_comb begin
    y_base   = ovr_fall ? y_implied : Y;
    y_nxt    = y_base;
    done_nxt = DONE;
    step_nxt = step_cnt;
    grp_nxt  = grp_cnt;
    if (ovr_act) begin
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
      y_nxt = OVR_VAL;
`endif
    end else if (hold_act) begin
      y_nxt    = SAFE_VAL;
      done_nxt = 1'b0;
      step_nxt = '0;
      grp_nxt  = '0;
    end else begin
      case (state)
        ST_STEP: begin
          if (step_hit) begin
            for (int g = 0; g < GROUPS; g++) begin
              if (g == int'(grp_cnt)) begin
                y_nxt[g*GW +: GW] = TIE_VAL[g*GW +: GW];
              end
            end
            step_nxt = '0;
            grp_nxt  = grp_cnt + 1'b1;
            if (last_grp) begin
              done_nxt = 1'b1;
            end
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
        default: begin
          step_nxt = step_cnt;
          grp_nxt  = grp_cnt;
        end
      endcase
    end
  end

  // Datapath registers: tie outputs, done flag and sequencing counters.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      Y        <= SAFE_VAL;
      DONE     <= 1'b0;
      step_cnt <= '0;
      grp_cnt  <= '0;
    end else begin
      Y        <= y_nxt;
      DONE     <= done_nxt;
      step_cnt <= step_nxt;
      grp_cnt  <= grp_nxt;
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_tiebank_seq.sv
// tb/tb_gf180mcu_osu_sc_12t_tiebank_seq.sv - directed self-checking bench for the sequenced tie-off bank
module tb_gf180mcu_osu_sc_12t_tiebank_seq;

  logic       CLK = 1'b0;
  logic       RN;
  logic       HOLD;
  logic [7:0] y8;
  logic       done8;
  logic [3:0] y4;
  logic       done4;
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
  logic       ovr;
  logic [7:0] ovr_val;
  logic [3:0] ovr_val4;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_12t_tiebank_seq #(
    .WIDTH(8), .GROUPS(4), .STEP_CYC(4), .TIE_VAL(8'hA5), .SAFE_VAL(8'h00)
  ) dut (
    .CLK(CLK),
    .RN(RN),
    .HOLD(HOLD),
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
    .OVR(ovr),
    .OVR_VAL(ovr_val),
`endif
    .Y(y8),
    .DONE(done8)
  );

  gf180mcu_osu_sc_12t_tiebank_seq #(
    .WIDTH(4), .GROUPS(1), .STEP_CYC(1), .TIE_VAL(4'hF), .SAFE_VAL(4'h0)
  ) dut_small (
    .CLK(CLK),
    .RN(RN),
    .HOLD(HOLD),
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
    .OVR(ovr),
    .OVR_VAL(ovr_val4),
`endif
    .Y(y4),
    .DONE(done4)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RN = 1'b0;
    HOLD = 1'b0;
    step(3);
    total_cnt++;
    if (y8 !== 8'h00) $display("FAIL reset_y: got %h expected 00", y8);
    else pass_cnt++;
    total_cnt++;
    if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8);
    else pass_cnt++;
    total_cnt++;
    if (y4 !== 4'h0) $display("FAIL reset_y_small: got %h expected 0", y4);
    else pass_cnt++;
  endtask

  task automatic test_sequence;
    logic [7:0] ey;
    logic       ed;
    @(negedge CLK);
    RN = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step(1);
      if (e < 6)       ey = 8'h00;
      else if (e < 10) ey = 8'h01;
      else if (e < 14) ey = 8'h05;
      else if (e < 18) ey = 8'h25;
      else             ey = 8'hA5;
      ed = (e >= 18);
      total_cnt++;
      if (y8 !== ey) $display("FAIL seq_y edge %0d: got %h expected %h", e, y8, ey);
      else pass_cnt++;
      total_cnt++;
      if (done8 !== ed) $display("FAIL seq_done edge %0d: got %b expected %b", e, done8, ed);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    @(negedge CLK);
    HOLD = 1'b1;
    step(3);
    total_cnt++;
    if (y8 !== 8'h00 || done8 !== 1'b0) $display("FAIL hold_force: got y=%h done=%b expected y=00 done=0", y8, done8);
    else pass_cnt++;
    @(negedge CLK);
    HOLD = 1'b0;
    step(3);
    total_cnt++;
    if (y8 !== 8'h00) $display("FAIL hold_pre_g0: got %h expected 00", y8);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (y8 !== 8'h01) $display("FAIL hold_g0: got %h expected 01", y8);
    else pass_cnt++;
    step(11);
    total_cnt++;
    if (y8 !== 8'h25 || done8 !== 1'b0) $display("FAIL hold_pre_done: got y=%h done=%b expected y=25 done=0", y8, done8);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (y8 !== 8'hA5 || done8 !== 1'b1) $display("FAIL hold_done: got y=%h done=%b expected y=a5 done=1", y8, done8);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    RN = 1'b0;
    step(1);
    @(negedge CLK);
    RN = 1'b1;
    step(12);
    chk8("mid_before", y8, 8'h05);
    #2;
    RN = 1'b0;
    #1;
    total_cnt++;
    if (y8 !== 8'h00 || done8 !== 1'b0) $display("FAIL mid_async: got y=%h done=%b expected y=00 done=0", y8, done8);
    else pass_cnt++;
    @(negedge CLK);
    RN = 1'b1;
    step(6);
    chk8("mid_restart_e5", y8, 8'h00);
    step(1);
    chk8("mid_restart_e6", y8, 8'h01);
  endtask

  task automatic test_hold_over_reset;
    @(negedge CLK);
    RN = 1'b0;
    HOLD = 1'b1;
    step(2);
    @(negedge CLK);
    RN = 1'b1;
    step(10);
    total_cnt++;
    if (y8 !== 8'h00 || done8 !== 1'b0) $display("FAIL hold_rst_held: got y=%h done=%b expected y=00 done=0", y8, done8);
    else pass_cnt++;
    @(negedge CLK);
    HOLD = 1'b0;
    step(3);
    chk8("hold_rst_pre", y8, 8'h00);
    step(1);
    chk8("hold_rst_g0", y8, 8'h01);
  endtask

  task automatic test_single_group;
    @(negedge CLK);
    RN = 1'b0;
    HOLD = 1'b0;
    #1;
    total_cnt++;
    if (y4 !== 4'h0 || done4 !== 1'b0) $display("FAIL small_reset: got y=%h done=%b expected y=0 done=0", y4, done4);
    else pass_cnt++;
    @(negedge CLK);
    RN = 1'b1;
    step(3);
    total_cnt++;
    if (y4 !== 4'h0 || done4 !== 1'b0) $display("FAIL small_e2: got y=%h done=%b expected y=0 done=0", y4, done4);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (y4 !== 4'hF || done4 !== 1'b1) $display("FAIL small_e3: got y=%h done=%b expected y=f done=1", y4, done4);
    else pass_cnt++;
  endtask

`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
  task automatic test_override;
    @(negedge CLK);
    RN = 1'b0;
    step(1);
    @(negedge CLK);
    RN = 1'b1;
    step(7);
    chk8("ovr_e6", y8, 8'h01);
    @(negedge CLK);
    ovr = 1'b1;
    ovr_val = 8'h3C;
    step(1);
    chk8("ovr_e7", y8, 8'h3C);
    step(3);
    chk8("ovr_e10", y8, 8'h3C);
    @(negedge CLK);
    ovr = 1'b0;
    step(1);
    chk8("ovr_fall_e11", y8, 8'h01);
    step(3);
    chk8("ovr_resume_e14", y8, 8'h05);
    step(7);
    total_cnt++;
    if (done8 !== 1'b0) $display("FAIL ovr_pre_done: got %b expected 0", done8);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (y8 !== 8'hA5 || done8 !== 1'b1) $display("FAIL ovr_done_e22: got y=%h done=%b expected y=a5 done=1", y8, done8);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RN = 1'b0;
    HOLD = 1'b0;
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
    ovr = 1'b0;
    ovr_val = 8'h00;
    ovr_val4 = 4'h0;
`endif
    test_reset();
    test_sequence();
    test_hold();
    test_reset_mid();
    test_hold_over_reset();
    test_single_group();
`ifdef GF180MCU_OSU_TIEBANK_OVERRIDE_EN
    test_override();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
